// File: rtl/issue_unit.sv
// Tomasulo issue stage: pops the instruction queue, allocates a station, renames via an 8-entry RAT.
// Optional ISSUE_STATS_EN adds saturating stall/issue counters.
module issue_unit #(
  parameter int N_ADD = 3,
  parameter int N_MUL = 2,
  parameter int N_LD  = 2
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             vazio,
  output logic             rtr,
  input  logic [15:0]      instrIn,
  input  logic [N_ADD-1:0] addFree,
  input  logic [N_MUL-1:0] mulFree,
  input  logic [N_LD-1:0]  ldFree,
  input  logic             cdbValid,
  input  logic [3:0]       cdbTag,
  output logic             issueValid,
  output logic [2:0]       issueOp,
  output logic [3:0]       issueTag,
  output logic [2:0]       issueRd,
  output logic [2:0]       issueRs,
  output logic [2:0]       issueRt,
  output logic             qjBusy,
  output logic             qkBusy,
  output logic [3:0]       qjTag,
  output logic [3:0]       qkTag
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0]      stallCnt,
  output logic [15:0]      issueCnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] POP  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state;
  logic [11:0] ir;
  logic [7:0]  rat_busy;
  logic [3:0]  rat_tag [8];

  logic [2:0] op, rd, rs, rt;
  logic       is_nop, fire, stall, writes_rd;
  logic [3:0] free_vec;
  logic [1:0] cls, idx;
  logic       any_free, found;
  logic       j_busy, k_busy;
  logic [3:0] j_tag, k_tag, new_tag;

  logic [2:0] held_op, held_rd, held_rs, held_rt;
  logic [3:0] held_tag, held_qj_tag, held_qk_tag;
  logic       held_qj_busy, held_qk_busy;

  // Low nibble of the instruction word carries no information.
  logic unused_low;
  assign unused_low = ^instrIn[3:0];

  assign op = ir[11:9];
  assign rd = ir[8:6];
  assign rs = ir[5:3];
  assign rt = ir[2:0];

  always_comb begin
    logic [3:0] add_pad, mul_pad, ld_pad;
    add_pad = '0;
    mul_pad = '0;
    ld_pad  = '0;
    add_pad[N_ADD-1:0] = addFree;
    mul_pad[N_MUL-1:0] = mulFree;
    ld_pad[N_LD-1:0]   = ldFree;
    is_nop = op[2] & op[1];
    case (op[2:1])
      2'b00:   begin cls = 2'b01; free_vec = add_pad; end
      2'b01:   begin cls = 2'b10; free_vec = mul_pad; end
      2'b10:   begin cls = 2'b11; free_vec = ld_pad;  end
      default: begin cls = 2'b00; free_vec = '0;      end
    endcase
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (free_vec[i] && !found) begin
        idx   = i[1:0];
        found = 1'b1;
      end
    end
    any_free  = |free_vec;
    new_tag   = {cls, idx};
    fire      = (state == HOLD) && !CLR && !is_nop && any_free;
    stall     = (state == HOLD) && !CLR && !is_nop && !any_free;
    writes_rd = (op != 3'b101);
  end

  // Source lookup reads the pre-update RAT; a matching CDB broadcast resolves the operand now.
  always_comb begin
    j_busy = rat_busy[rs] && !(cdbValid && rat_tag[rs] == cdbTag);
    j_tag  = j_busy ? rat_tag[rs] : '0;
    k_busy = rat_busy[rt] && !(cdbValid && rat_tag[rt] == cdbTag) && (op != 3'b100);
    k_tag  = k_busy ? rat_tag[rt] : '0;
  end

  assign rtr        = (state == IDLE) && !vazio && !CLR;
  assign issueValid = fire;
  assign issueOp    = fire ? op      : held_op;
  assign issueTag   = fire ? new_tag : held_tag;
  assign issueRd    = fire ? rd      : held_rd;
  assign issueRs    = fire ? rs      : held_rs;
  assign issueRt    = fire ? rt      : held_rt;
  assign qjBusy     = fire ? j_busy  : held_qj_busy;
  assign qkBusy     = fire ? k_busy  : held_qk_busy;
  assign qjTag      = fire ? j_tag   : held_qj_tag;
  assign qkTag      = fire ? k_tag   : held_qk_tag;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      case (state)
        IDLE:    if (!vazio) state <= POP;
        POP: begin
          ir    <= instrIn[15:4];
          state <= HOLD;
        end
        HOLD:    if (is_nop || any_free) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      held_op      <= '0;
      held_tag     <= '0;
      held_rd      <= '0;
      held_rs      <= '0;
      held_rt      <= '0;
      held_qj_busy <= 1'b0;
      held_qk_busy <= 1'b0;
      held_qj_tag  <= '0;
      held_qk_tag  <= '0;
    end else if (fire) begin
      held_op      <= op;
      held_tag     <= new_tag;
      held_rd      <= rd;
      held_rs      <= rs;
      held_rt      <= rt;
      held_qj_busy <= j_busy;
      held_qk_busy <= k_busy;
      held_qj_tag  <= j_tag;
      held_qk_tag  <= k_tag;
    end
  end

  // Issue write is applied after the CDB clear so it wins on the same entry.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      rat_busy <= '0;
      for (int unsigned i = 0; i < 8; i++) rat_tag[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (cdbValid && rat_busy[i] && rat_tag[i] == cdbTag) begin
          rat_busy[i] <= 1'b0;
          rat_tag[i]  <= '0;
        end
        if (fire && writes_rd && rd == i[2:0]) begin
          rat_busy[i] <= 1'b1;
          rat_tag[i]  <= new_tag;
        end
      end
    end
  end

`ifdef ISSUE_STATS_EN
  always_ff @(posedge CLK) begin
    if (CLR) begin
      stallCnt <= '0;
      issueCnt <= '0;
    end else begin
      if (stall && stallCnt != '1) stallCnt <= stallCnt + 16'd1;
      if (fire && issueCnt != '1)  issueCnt <= issueCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: fetch/issue timing, renaming, CDB bypass/clear, stall and reset.
// Stats counters are checked only when ISSUE_STATS_EN is defined.
module tb_issue_unit;

  logic        CLK = 1'b0;
  logic        CLR, vazio, rtr, cdbValid;
  logic [15:0] instrIn;
  logic [2:0]  addFree;
  logic [1:0]  mulFree, ldFree;
  logic [3:0]  cdbTag;
  logic        issueValid, qjBusy, qkBusy;
  logic [2:0]  issueOp, issueRd, issueRs, issueRt;
  logic [3:0]  issueTag, qjTag, qkTag;
`ifdef ISSUE_STATS_EN
  logic [15:0] stallCnt, issueCnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  issue_unit #(.N_ADD(3), .N_MUL(2), .N_LD(2)) dut (
    .CLK(CLK), .CLR(CLR), .vazio(vazio), .rtr(rtr), .instrIn(instrIn),
    .addFree(addFree), .mulFree(mulFree), .ldFree(ldFree),
    .cdbValid(cdbValid), .cdbTag(cdbTag),
    .issueValid(issueValid), .issueOp(issueOp), .issueTag(issueTag),
    .issueRd(issueRd), .issueRs(issueRs), .issueRt(issueRt),
    .qjBusy(qjBusy), .qkBusy(qkBusy), .qjTag(qjTag), .qkTag(qkTag)
`ifdef ISSUE_STATS_EN
    , .stallCnt(stallCnt), .issueCnt(issueCnt)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 4'b0000};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at an IDLE negedge; returns at the HOLD negedge of the fetched instruction.
  task automatic fetch(input logic [15:0] ins);
    cdbValid = 1'b0;
    vazio    = 1'b0;
    instrIn  = ins;
    #1;
    chk("idle_rtr", {15'b0, rtr}, 16'd1);
    @(negedge CLK);
    vazio = 1'b1;
    #1;
    chk("pop_rtr", {15'b0, rtr}, 16'd0);
    chk("pop_iv", {15'b0, issueValid}, 16'd0);
    @(negedge CLK);
  endtask

  initial begin
    CLR = 1'b1; vazio = 1'b1; instrIn = '0;
    addFree = '0; mulFree = '0; ldFree = '0;
    cdbValid = 1'b0; cdbTag = '0;
    @(negedge CLK);
    #1;
    chk("rst_rtr", {15'b0, rtr}, 16'd0);
    chk("rst_iv", {15'b0, issueValid}, 16'd0);
    @(negedge CLK);
    CLR = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("empty_rtr", {15'b0, rtr}, 16'd0);
      chk("empty_iv", {15'b0, issueValid}, 16'd0);
      @(negedge CLK);
    end
    chk("rst_tag", {12'b0, issueTag}, 16'd0);
    chk("rst_op", {13'b0, issueOp}, 16'd0);
    chk("rst_qj", {11'b0, qjBusy, qjTag}, 16'd0);
    chk("rst_qk", {11'b0, qkBusy, qkTag}, 16'd0);
`ifdef ISSUE_STATS_EN
    chk("rst_stall", stallCnt, 16'd0);
    chk("rst_icnt", issueCnt, 16'd0);
`endif

    // ADD r1,r2,r3
    addFree = 3'b111; mulFree = 2'b00; ldFree = 2'b00;
    fetch(16'h0530);
    #1;
    chk("add_iv", {15'b0, issueValid}, 16'd1);
    chk("add_tag", {12'b0, issueTag}, 16'h0004);
    chk("add_op", {13'b0, issueOp}, 16'd0);
    chk("add_regs", {7'b0, issueRd, issueRs, issueRt}, {7'b0, 3'd1, 3'd2, 3'd3});
    chk("add_qj", {11'b0, qjBusy, qjTag}, 16'd0);
    chk("add_qk", {11'b0, qkBusy, qkTag}, 16'd0);
    chk("hold_rtr", {15'b0, rtr}, 16'd0);
    @(negedge CLK);
    #1;
    chk("after_iv", {15'b0, issueValid}, 16'd0);
    chk("after_tag", {12'b0, issueTag}, 16'h0004);

    // MUL r4,r1,r1 depends on the ADD twice
    mulFree = 2'b10;
    fetch(enc(3'b010, 3'd4, 3'd1, 3'd1));
    #1;
    chk("mul_iv", {15'b0, issueValid}, 16'd1);
    chk("mul_tag", {12'b0, issueTag}, 16'h0009);
    chk("mul_qj", {11'b0, qjBusy, qjTag}, 16'h0014);
    chk("mul_qk", {11'b0, qkBusy, qkTag}, 16'h0014);
    @(negedge CLK);

    // SUB r2,r4,r3 stalls with no adder free
    addFree = 3'b000;
    fetch(enc(3'b001, 3'd2, 3'd4, 3'd3));
    vazio = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_iv", {15'b0, issueValid}, 16'd0);
      chk("stall_rtr", {15'b0, rtr}, 16'd0);
      @(negedge CLK);
    end
    vazio = 1'b1;
    addFree = 3'b100;
    #1;
    chk("sub_iv", {15'b0, issueValid}, 16'd1);
    chk("sub_tag", {12'b0, issueTag}, 16'h0006);
    chk("sub_op", {13'b0, issueOp}, 16'd1);
    chk("sub_qj", {11'b0, qjBusy, qjTag}, 16'h0019);
    chk("sub_qk", {11'b0, qkBusy, qkTag}, 16'd0);
`ifdef ISSUE_STATS_EN
    chk("stall_cnt", stallCnt, 16'd5);
    chk("icnt_3", issueCnt, 16'd2);
`endif
    @(negedge CLK);

    // ADD r5,r1,r0 while CDB broadcasts r1's producer
    addFree = 3'b110;
    fetch(enc(3'b000, 3'd5, 3'd1, 3'd0));
    cdbValid = 1'b1; cdbTag = 4'b0100;
    #1;
    chk("byp_tag", {12'b0, issueTag}, 16'h0005);
    chk("byp_qj", {11'b0, qjBusy, qjTag}, 16'd0);
    chk("byp_qk", {11'b0, qkBusy, qkTag}, 16'd0);
    @(negedge CLK);
    cdbValid = 1'b0;

    // MUL r1,r1,r2: r1 now cleared, r2 still pending on the SUB
    mulFree = 2'b01;
    fetch(enc(3'b010, 3'd1, 3'd1, 3'd2));
    #1;
    chk("clr_tag", {12'b0, issueTag}, 16'h0008);
    chk("clr_qj", {11'b0, qjBusy, qjTag}, 16'd0);
    chk("clr_qk", {11'b0, qkBusy, qkTag}, 16'h0016);
    @(negedge CLK);

    // ADD r1,r1,r4 with CDB clearing r1's entry in the same cycle
    addFree = 3'b001;
    fetch(enc(3'b000, 3'd1, 3'd1, 3'd4));
    cdbValid = 1'b1; cdbTag = 4'b1000;
    #1;
    chk("conf_tag", {12'b0, issueTag}, 16'h0004);
    chk("conf_qj", {11'b0, qjBusy, qjTag}, 16'd0);
    chk("conf_qk", {11'b0, qkBusy, qkTag}, 16'h0019);
    @(negedge CLK);
    cdbValid = 1'b0;

    // LD r6,r1,r4: r1 holds the new tag, rt ignored for loads
    ldFree = 2'b11;
    fetch(enc(3'b100, 3'd6, 3'd1, 3'd4));
    #1;
    chk("ld_tag", {12'b0, issueTag}, 16'h000C);
    chk("ld_op", {13'b0, issueOp}, 16'd4);
    chk("ld_qj", {11'b0, qjBusy, qjTag}, 16'h0014);
    chk("ld_qk", {11'b0, qkBusy, qkTag}, 16'd0);
    @(negedge CLK);

    // NOP, then ST r0,r2,r3
    fetch(16'hC000);
    #1;
    chk("nop_iv", {15'b0, issueValid}, 16'd0);
    @(negedge CLK);
    ldFree = 2'b10;
    fetch(enc(3'b101, 3'd0, 3'd2, 3'd3));
    #1;
    chk("st_iv", {15'b0, issueValid}, 16'd1);
    chk("st_tag", {12'b0, issueTag}, 16'h000D);
    chk("st_op", {13'b0, issueOp}, 16'd5);
    chk("st_qj", {11'b0, qjBusy, qjTag}, 16'h0016);
    chk("st_qk", {11'b0, qkBusy, qkTag}, 16'd0);
    @(negedge CLK);

    // ADD r7,r0,r6: r0 untouched by the store, r6 pending on the load
    addFree = 3'b111;
    fetch(enc(3'b000, 3'd7, 3'd0, 3'd6));
    #1;
    chk("st_rat_tag", {12'b0, issueTag}, 16'h0004);
    chk("st_rat_qj", {11'b0, qjBusy, qjTag}, 16'd0);
    chk("st_rat_qk", {11'b0, qkBusy, qkTag}, 16'h001C);
`ifdef ISSUE_STATS_EN
    chk("icnt_8", issueCnt, 16'd8);
`endif
    @(negedge CLK);
`ifdef ISSUE_STATS_EN
    #1;
    chk("icnt_9", issueCnt, 16'd9);
`endif

    // Reset while stalled in HOLD
    addFree = 3'b000;
    fetch(enc(3'b001, 3'd3, 3'd1, 3'd1));
    #1;
    chk("pre_clr_iv", {15'b0, issueValid}, 16'd0);
    @(negedge CLK);
    CLR = 1'b1; addFree = 3'b111;
    #1;
    chk("clr_iv", {15'b0, issueValid}, 16'd0);
    chk("clr_rtr", {15'b0, rtr}, 16'd0);
    @(negedge CLK);
    CLR = 1'b0;
    #1;
    chk("post_iv", {15'b0, issueValid}, 16'd0);
    chk("post_tag", {12'b0, issueTag}, 16'd0);
    chk("post_op", {13'b0, issueOp}, 16'd0);
    chk("post_regs", {7'b0, issueRd, issueRs, issueRt}, 16'd0);
    chk("post_qj", {11'b0, qjBusy, qjTag}, 16'd0);
    chk("post_qk", {11'b0, qkBusy, qkTag}, 16'd0);
`ifdef ISSUE_STATS_EN
    chk("post_stall", stallCnt, 16'd0);
    chk("post_icnt", issueCnt, 16'd0);
`endif
    fetch(enc(3'b000, 3'd2, 3'd1, 3'd4));
    #1;
    chk("rs_iv", {15'b0, issueValid}, 16'd1);
    chk("rs_op", {13'b0, issueOp}, 16'd0);
    chk("rs_rd", {13'b0, issueRd}, 16'd2);
    chk("rs_tag", {12'b0, issueTag}, 16'h0004);
    chk("rs_qj", {11'b0, qjBusy, qjTag}, 16'd0);
    chk("rs_qk", {11'b0, qkBusy, qkTag}, 16'd0);
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/issue_unit.md
Name: issue_unit

Overview:
- Tomasulo issue stage, directly downstream of the instruction queue.
- Pops 16-bit instructions from the queue (rtr/vazio/instrOut handshake) and decodes them.
- Allocates a free reservation station or load buffer and renames operands through an 8-entry register status table (RAT).
- Emits a one-cycle issue bundle to the station array; the CDB clears RAT entries on broadcast.

Parameters:
- N_ADD, 3, adder/subtractor reservation stations (1..4)
- N_MUL, 2, multiplier/divider reservation stations (1..4)
- N_LD, 2, load/store buffers (1..4)

Ports:
- CLK  in  1  clock, all state on rising edge
- CLR  in  1  synchronous active-high reset
- vazio  in  1  queue empty flag
- rtr  out  1  queue pop request; queue presents instrIn on the following cycle
- instrIn  in  16  instruction from queue output
- addFree  in  N_ADD  per-station free flags, adder class
- mulFree  in  N_MUL  per-station free flags, multiplier class
- ldFree  in  N_LD  per-buffer free flags, load/store class
- cdbValid  in  1  common data bus broadcast valid
- cdbTag  in  4  tag being broadcast
- issueValid  out  1  one-cycle issue strobe
- issueOp  out  3  opcode
- issueTag  out  4  allocated station tag
- issueRd, issueRs, issueRt  out  3 each  register fields
- qjBusy, qkBusy  out  1 each  source operand pending
- qjTag, qkTag  out  4 each  producing tag when busy, else 0

Behaviour:
- Instruction format:
  - [15:13] op: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 LD, 101 ST, 110 NOP, 111 reserved (handled as NOP).
  - [12:10] rd, [9:7] rs, [6:4] rt, [3:0] ignored.
- Classes: ADD/SUB → adder; MUL/DIV → multiplier; LD/ST → load.
- Tag encoding: [3:2] class (01 add, 10 mul, 11 load), [1:0] station index. Tag 0 = none.
- FSM states:
  - IDLE: rtr = ~vazio (combinational). If ~vazio, go to POP; else stay.
  - POP: rtr=0. Latch instrIn into the instruction register, go to HOLD.
  - HOLD: decode the latched instruction.
    - NOP/reserved: discard, no issue, go to IDLE.
    - Target class has any free bit: pick the lowest-index free bit, assert issueValid for exactly this cycle, update RAT, go to IDLE.
    - No free bit: stay in HOLD (stall), issueValid=0, rtr=0.
- Throughput: best case 1 instruction per 3 cycles. rtr is never asserted outside IDLE.
- RAT: 8 entries {busy, tag[3:0]}.
  - On issue of ADD/SUB/MUL/DIV/LD: RAT[rd] <= {1, issueTag}.
  - ST writes no RAT entry; ST reads rs (base) and rt (data).
  - LD reads rs only: qkBusy=0, qkTag=0.
- Operand lookup (valid during issueValid):
  - qjBusy/qjTag come from RAT[rs]; qkBusy/qkTag come from RAT[rt].
  - CDB bypass: if cdbValid and cdbTag equals the entry's tag in the same cycle, report busy=0, tag=0.
- CDB clear: every cycle with cdbValid, each RAT entry whose busy=1 and tag==cdbTag is cleared.
- Same-cycle conflict: issue write to RAT[rd] takes priority over a CDB clear of the same entry.
- Self-dependency (rd equals rs or rt): sources read the RAT value before the update.
- Outputs other than issueValid hold their last values; they are only meaningful when issueValid=1.
- Reset (CLR=1 at edge), including mid-operation: state=IDLE, all RAT busy=0 and tags=0, issueValid=0, issueOp/issueTag/issue*/q* = 0. Any latched instruction is dropped. rtr=0 during the reset cycle.
- Free flags are sampled only in HOLD. The station array deasserts the chosen free bit on the cycle after issueValid.

Optional Feature:
- Macro: ISSUE_STATS_EN.
- Defined: adds outputs stallCnt[15:0] and issueCnt[15:0].
  - stallCnt increments each cycle in HOLD with no free station.
  - issueCnt increments on each issueValid.
  - Both saturate at 16'hFFFF and clear on CLR.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then vazio=1 for 10 cycles → rtr=0, issueValid=0, all RAT entries not busy.
- ADD r1,r2,r3 (16'h0530) with addFree=3'b111 → rtr at cycle 0, issueValid at cycle 2, issueTag=4'b0100, qjBusy=qkBusy=0; RAT[1]=tag 0100.
- MUL r4,r1,r1 right after the ADD, mulFree=2'b10 → issueTag=4'b1001, qjBusy=qkBusy=1, qjTag=qkTag=4'b0100.
- addFree=0 with SUB queued → HOLD for 5 cycles, no rtr, no issueValid (stallCnt=5 if ISSUE_STATS_EN). Raise addFree[2] → issue with tag 4'b0110.
- cdbValid with cdbTag=4'b0100 on the same cycle as issue of ADD r5,r1,r0 → qjBusy=0; RAT[1] cleared afterwards. Repeat with rd=r1 → RAT[1] holds the new tag.
- NOP (16'hC000) and ST r0,r2,r3 → NOP produces no issueValid; ST issues to the load class with RAT unchanged. CLR asserted while in HOLD → IDLE next cycle, RAT cleared.
